// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection arbiter.
// - Arbiter FSM state encoding.
// - Flit field offsets: the payload sits in the low bits. Destination x and
//   then destination y sit directly above the payload.
// - Destination legality check against the mesh dimensions.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no grant held
    ST_LOCK = 2'd1,  // grant held, flits forwarded until last
    ST_DROP = 2'd2   // grant held, flits swallowed until last
  } arb_state_e;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  function automatic int unsigned dest_x_lsb(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned dest_y_lsb(input int unsigned data_width,
                                             input int unsigned x_size);
    return data_width + x_size;
  endfunction

  function automatic logic dest_legal(input int unsigned x,
                                      input int unsigned y,
                                      input int unsigned mesh_x,
                                      input int unsigned mesh_y);
    return (x < mesh_x) && (y < mesh_y);
  endfunction

endpackage

// File: rtl/noc_skid_buf.sv
// Two-entry registered output buffer in front of the mesh injection port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     write side; in_ready = fewer than two entries held
//   in_data               entry written on in_valid & in_ready
//   out_valid/out_ready   read side; out_valid = at least one entry held
//   out_data              head entry (registered)
//   count                 occupancy, 0..2
// Handshake: a transfer happens on a side exactly in the cycle where both
// valid and ready are high on that side. in_ready does not depend on
// out_ready, so a full buffer refuses writes even while it is being read.
module noc_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         push;
  logic         pop;

  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        // With a single entry, a simultaneous push and pop replaces the head.
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // Full: only a pop can happen, and the tail moves up.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_data = head_q;
  assign count    = count_q;

endmodule

// File: rtl/noc_inject_arbiter.sv
// Shares one mesh PE injection port between N local requesters.
// A work-conserving round-robin picks a requester. A multi-flit packet then
// keeps the grant until its last flit. A packet whose destination lies
// outside the mesh is consumed and discarded. Discards set a sticky error
// flag and increment a saturating drop count.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/req_ready [N]    per-requester flit handshake
//   req_data [N*total_width]   requester i flit at [i*total_width +: total_width]
//   req_last [N]               flit is the last of its packet
//   o_valid/i_ready            injection port handshake
//   o_data, o_last             head flit and its last flag
//   err_clr                    clears err_dest and drop_cnt
//   err_dest, drop_cnt         sticky illegal-destination flag, drop count
//   dbg_state, dbg_ptr         arbiter FSM state and round-robin pointer
// Handshake: every valid/ready pair transfers exactly when both are high in
// the same cycle. A sender holds data stable while valid is high and ready
// is low.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned X           = 2,
  parameter int unsigned Y           = 2,
  parameter int unsigned data_width  = 129,
  parameter int unsigned x_size      = 1,
  parameter int unsigned y_size      = 1,
  parameter int unsigned total_width = x_size + y_size + data_width
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0]                         req_valid,
  input  logic [N*total_width-1:0]             req_data,
  input  logic [N-1:0]                         req_last,
  output logic [N-1:0]                         req_ready,
  output logic                                 o_valid,
  output logic [total_width-1:0]               o_data,
  output logic                                 o_last,
  input  logic                                 i_ready,
  input  logic                                 err_clr,
  output logic                                 err_dest,
  output logic [7:0]                           drop_cnt,
  output arb_state_e                           dbg_state,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] dbg_ptr
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int          NI = int'(N);
  localparam int unsigned XL = dest_x_lsb(data_width);
  localparam int unsigned YL = dest_y_lsb(data_width, x_size);

  // Index following i in cyclic order; with N=1 this is always 0.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    int t;
    t = int'(i) + 1;
    if (t >= NI) t = 0;
    return IW'(t);
  endfunction

  // Returns {found, idx}: the first valid requester at or after p, cyclic.
  // The loop runs downward so the lowest cyclic distance is written last.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0]  v,
                                          input logic [IW-1:0] p);
    logic [IW:0] r;
    int          j;
    r = '0;
    for (int k = NI - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NI) j = j - NI;
      if (v[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          gnt_q, gnt_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic                   err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;

  logic [IW:0]            pick;
  logic                   pick_found;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          sel_idx;
  logic [total_width-1:0] sel_flit;
  logic                   sel_last;
  logic [x_size-1:0]      sel_x;
  logic [y_size-1:0]      sel_y;
  logic                   sel_legal;
  logic                   space;
  logic [N-1:0]           ready_vec;
  logic                   accept;
  logic                   push;
  logic                   drop;

  logic                   buf_in_ready;
  logic [total_width:0]   buf_out;
  logic [1:0]             buf_count;

  always_comb begin
    pick       = rr_pick(req_valid, ptr_q);
    pick_found = pick[IW];
    pick_idx   = pick[IW-1:0];
    sel_idx    = (state_q == ST_IDLE) ? pick_idx : gnt_q;
    sel_flit   = req_data[sel_idx*total_width +: total_width];
    sel_last   = req_last[sel_idx];
    sel_x      = sel_flit[XL +: x_size];
    sel_y      = sel_flit[YL +: y_size];
    sel_legal  = dest_legal(32'(sel_x), 32'(sel_y), X, Y);
    space      = buf_in_ready;

    ready_vec = '0;
    case (state_q)
      ST_IDLE: if (pick_found && space) ready_vec[pick_idx] = 1'b1;
      ST_LOCK: if (space) ready_vec[gnt_q] = 1'b1;
      // A dropped packet never enters the buffer, so it drains at full rate.
      ST_DROP: ready_vec[gnt_q] = 1'b1;
      default: ;
    endcase
    // Nobody is acknowledged while reset is held.
    ready_vec = ready_vec & {N{rst}};

    accept = |(ready_vec & req_valid);
    push   = accept && (((state_q == ST_IDLE) && sel_legal) || (state_q == ST_LOCK));
    drop   = accept && (state_q == ST_IDLE) && !sel_legal;

    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (sel_last) begin
          ptr_d = next_idx(pick_idx);
        end else begin
          gnt_d   = pick_idx;
          state_d = sel_legal ? ST_LOCK : ST_DROP;
        end
      end else if (sel_last) begin
        state_d = ST_IDLE;
        ptr_d   = next_idx(gnt_q);
      end
    end

    // A drop in the same cycle as a clear wins, so the count restarts at 1.
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
    if (drop) begin
      err_d = 1'b1;
      if (cnt_d != DROP_CNT_MAX) cnt_d = cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  noc_skid_buf #(
    .W (total_width + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (push),
    .in_ready  (buf_in_ready),
    .in_data   ({sel_last, sel_flit}),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .out_data  (buf_out),
    .count     (buf_count)
  );

  assign req_ready = ready_vec;
  assign o_data    = buf_out[total_width-1:0];
  assign o_last    = buf_out[total_width];
  assign err_dest  = err_q;
  assign drop_cnt  = cnt_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule
